// File: rtl/gp_mem_adapter_if.sv
// Request/response handshake bundle between a generic-payload decoder
// (master) and the memory adapter (slave).
interface gp_mem_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;

  modport master (
    output req_valid, req_cmd, req_addr, req_data, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/gp_mem_adapter.sv
// Generic-payload to synchronous single-port memory adapter.
// Reads take two edges (address registered by the memory, then sampled),
// full writes go straight out, partial writes do read-modify-write.
module gp_mem_adapter #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  gp_mem_adapter_if.slave    bus,
  output logic [7:0]         mem_addr_o,
  output logic [31:0]        mem_data_o,
  output logic               mem_we_o,
  input  logic [31:0]        mem_q_i,
  output logic [15:0]        ok_cnt_o,
  output logic [15:0]        err_cnt_o
);

  localparam logic [1:0] CMD_READ   = 2'd0;
  localparam logic [1:0] CMD_WRITE  = 2'd1;
  localparam logic [1:0] CMD_IGNORE = 2'd2;
  localparam logic [1:0] CMD_ILL    = 2'd3;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_ADDR_ERR = 2'd1;
  localparam logic [1:0] ST_CMD_ERR  = 2'd2;
  localparam logic [1:0] ST_BE_ERR   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_CAP  = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // Expand byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_status_q;
  logic [7:0]  mem_addr_q;
  logic [31:0] mem_data_q;
  logic        mem_we_q;
  logic [15:0] ok_cnt_q;
  logic [15:0] err_cnt_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        is_write_q;

  logic [32:0] diff_d;
  logic [32:0] word_idx_d;
  logic [1:0]  chk_status_d;

  // Decode the offered request: word index and first-match error status.
  always_comb begin
    diff_d       = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    word_idx_d   = diff_d >> 2;
    chk_status_d = ST_OK;
    if (bus.req_cmd == CMD_ILL) begin
      chk_status_d = ST_CMD_ERR;
    end else if (bus.req_cmd == CMD_READ || bus.req_cmd == CMD_WRITE) begin
      if (bus.req_addr[1:0] != 2'b00 || diff_d[32] ||
          word_idx_d >= 33'(MEM_WORDS)) begin
        chk_status_d = ST_ADDR_ERR;
      end else if (bus.req_be == 4'h0) begin
        chk_status_d = ST_BE_ERR;
      end else begin
        chk_status_d = ST_OK;
      end
    end else begin
      chk_status_d = ST_OK;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'h0;
      rsp_status_q <= 2'd0;
      mem_addr_q   <= 8'h0;
      mem_data_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      ok_cnt_q     <= 16'h0;
      err_cnt_q    <= 16'h0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      is_write_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            wdata_q     <= bus.req_data;
            be_q        <= bus.req_be;
            is_write_q  <= (bus.req_cmd == CMD_WRITE);
            if (chk_status_d != ST_OK || bus.req_cmd == CMD_IGNORE) begin
              rsp_valid_q  <= 1'b1;
              rsp_data_q   <= 32'h0;
              rsp_status_q <= chk_status_d;
              state_q      <= S_RESP;
            end else begin
              mem_addr_q <= word_idx_d[7:0];
              if (bus.req_cmd == CMD_WRITE && bus.req_be == 4'hF) begin
                mem_data_q <= bus.req_data;
                mem_we_q   <= 1'b1;
                state_q    <= S_WR;
              end else begin
                state_q <= S_RD_WAIT;
              end
            end
          end
        end
        S_RD_WAIT: begin
          state_q <= S_RD_CAP;
        end
        S_RD_CAP: begin
          if (is_write_q) begin
            // Merge new enabled bytes over the old word.
            mem_data_q <= (wdata_q & be_mask(be_q)) | (mem_q_i & ~be_mask(be_q));
            mem_we_q   <= 1'b1;
            state_q    <= S_WR;
          end else begin
            rsp_data_q   <= mem_q_i & be_mask(be_q);
            rsp_status_q <= ST_OK;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WR: begin
          mem_we_q     <= 1'b0;
          rsp_data_q   <= 32'h0;
          rsp_status_q <= ST_OK;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
            if (rsp_status_q == ST_OK) begin
              if (ok_cnt_q != 16'hFFFF) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
              end
            end else begin
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign mem_we_o       = mem_we_q;
  assign ok_cnt_o       = ok_cnt_q;
  assign err_cnt_o      = err_cnt_q;

endmodule
